vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vm_pkg.sv | 21 ++
 rtl/tick_gen.sv | 33 +++
 rtl/vending_machine_param.sv | 197 +++++++++++++++++++
 tb/tb_vending_machine_param.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared FSM states and coin constants for the vending machine
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vm_state_t;

    // One-hot coin codes as seen on the coin and change_coin buses
    localparam logic [2:0] NICKEL  = 3'b001;
    localparam logic [2:0] DIME    = 3'b010;
    localparam logic [2:0] QUARTER = 3'b100;

    // Coin values in cents
    localparam int unsigned NICKEL_VAL  = 5;
    localparam int unsigned DIME_VAL    = 10;
    localparam int unsigned QUARTER_VAL = 25;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-clk tick pulse every TICK_DIV clk cycles
// Ports:
//   clk  - system clock
//   clr  - asynchronous active-high reset, restarts the count from 0
//   tick - high for one clk cycle at the end of every TICK_DIV-cycle period
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Tick is decoded from the last count value, so the first tick after clr
    // is consumed by the edge TICK_DIV cycles after release.
    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parameterised coin-operated vending machine
// Ports:
//   clk          - system clock
//   clr          - asynchronous active-high reset
//   coin[2:0]    - one-hot coin insert: [2] quarter, [1] dime, [0] nickel
//   choice[N-1:0]- one-hot item select
//   cancel       - refund request
//   item[N-1:0]  - one-hot vend indicator
//   total        - current credit
//   cost_or_ret  - price of the selected item while short, else remaining change
//   change_coin  - one-hot coin returned this tick
//   coin_reject  - inserted coin returned this tick
//   busy         - high while vending or paying out change
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int                            MAX_CREDIT = 95,
    parameter int                            TICK_DIV   = 100000000
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [2:0]           coin,
    input  logic [NUM_ITEMS-1:0] choice,
    input  logic                 cancel,
    output logic [NUM_ITEMS-1:0] item,
    output logic [CREDIT_W-1:0]  total,
    output logic [CREDIT_W-1:0]  cost_or_ret,
    output logic [2:0]           change_coin,
    output logic                 coin_reject,
    output logic                 busy
);

    localparam logic [CREDIT_W-1:0] C_MAX     = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C_NICKEL  = CREDIT_W'(NICKEL_VAL);
    localparam logic [CREDIT_W-1:0] C_DIME    = CREDIT_W'(DIME_VAL);
    localparam logic [CREDIT_W-1:0] C_QUARTER = CREDIT_W'(QUARTER_VAL);

    // Credit plus the largest coin must never wrap the credit register.
    generate
        if ((MAX_CREDIT + 25) > ((2 ** CREDIT_W) - 1)) begin : g_credit_w_check
            $error("CREDIT_W too narrow to hold MAX_CREDIT + 25");
        end
    endgenerate

    logic                 w_tick;
    vm_state_t            r_state, w_state_n;
    logic [CREDIT_W-1:0]  r_total, w_total_n;
    logic [CREDIT_W-1:0]  r_cor, w_cor_n;
    logic [NUM_ITEMS-1:0] r_item, w_item_n;
    logic [2:0]           r_change, w_change_n;
    logic                 r_reject, w_reject_n;

    logic [CREDIT_W-1:0]  w_coin_val;
    logic [CREDIT_W-1:0]  w_sum;
    logic [CREDIT_W-1:0]  w_price;
    logic [CREDIT_W-1:0]  w_ret_val;
    logic [2:0]           w_ret_coin;
    logic                 w_coin_any;
    logic                 w_coin_fit;
    logic                 w_choice_ok;
    logic                 w_vend_pre;
    logic                 w_vend_post;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .tick (w_tick)
    );

    // Multi-hot or empty coin decodes to zero value
    always_comb begin
        case (coin)
            NICKEL:  w_coin_val = C_NICKEL;
            DIME:    w_coin_val = C_DIME;
            QUARTER: w_coin_val = C_QUARTER;
            default: w_coin_val = '0;
        endcase
    end

    always_comb begin
        w_price = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (choice[k]) begin
                w_price = PRICES[k*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Largest coin not exceeding the outstanding change. A sub-nickel residue
    // (only possible with odd prices) is dropped so payout always terminates.
    always_comb begin
        if (r_cor >= C_QUARTER) begin
            w_ret_coin = QUARTER;
            w_ret_val  = C_QUARTER;
        end else if (r_cor >= C_DIME) begin
            w_ret_coin = DIME;
            w_ret_val  = C_DIME;
        end else if (r_cor >= C_NICKEL) begin
            w_ret_coin = NICKEL;
            w_ret_val  = C_NICKEL;
        end else begin
            w_ret_coin = '0;
            w_ret_val  = r_cor;
        end
    end

    assign w_coin_any  = |coin;
    assign w_sum       = r_total + w_coin_val;
    assign w_coin_fit  = (w_coin_val != '0) && (w_sum <= C_MAX);
    assign w_choice_ok = $onehot(choice);
    // Existing credit already covers the price: the new coin is not needed and goes back.
    assign w_vend_pre  = w_choice_ok && (r_total >= w_price);
    // Only the coin inserted this tick makes up the price: the coin is consumed.
    assign w_vend_post = w_choice_ok && w_coin_fit && (w_sum >= w_price);

    always_comb begin
        w_state_n  = r_state;
        w_total_n  = r_total;
        w_cor_n    = r_cor;
        w_item_n   = r_item;
        w_change_n = '0;
        w_reject_n = 1'b0;
        case (r_state)
            IDLE, CREDIT: begin
                if (cancel && (r_state == CREDIT) && (r_total != '0)) begin
                    w_cor_n    = r_total;
                    w_total_n  = '0;
                    w_state_n  = CHANGE;
                    w_reject_n = w_coin_any;
                end else if (w_vend_pre || w_vend_post) begin
                    w_cor_n    = (w_vend_pre ? r_total : w_sum) - w_price;
                    w_total_n  = '0;
                    w_item_n   = choice;
                    w_state_n  = VEND;
                    w_reject_n = w_vend_pre && w_coin_any;
                end else begin
                    if (w_choice_ok) begin
                        w_cor_n = w_price;
                    end
                    if (w_coin_fit) begin
                        w_total_n = w_sum;
                        w_state_n = CREDIT;
                    end else begin
                        w_reject_n = w_coin_any;
                    end
                end
            end
            VEND: begin
                w_item_n   = '0;
                w_state_n  = (r_cor != '0) ? CHANGE : IDLE;
                w_reject_n = w_coin_any;
            end
            CHANGE: begin
                w_change_n = w_ret_coin;
                w_cor_n    = r_cor - w_ret_val;
                w_reject_n = w_coin_any;
                if (r_cor == w_ret_val) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= IDLE;
            r_total  <= '0;
            r_cor    <= '0;
            r_item   <= '0;
            r_change <= '0;
            r_reject <= 1'b0;
        end else if (w_tick) begin
            r_state  <= w_state_n;
            r_total  <= w_total_n;
            r_cor    <= w_cor_n;
            r_item   <= w_item_n;
            r_change <= w_change_n;
            r_reject <= w_reject_n;
        end
    end

    assign item        = r_item;
    assign total       = r_total;
    assign cost_or_ret = r_cor;
    assign change_coin = r_change;
    assign coin_reject = r_reject;
    assign busy        = (r_state == VEND) || (r_state == CHANGE);

endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - scoreboard bench for vending_machine_param
module tb_vending_machine_param;

    localparam int TD   = 4;
    localparam int NI   = 4;
    localparam int CW   = 8;
    localparam int MAXC = 95;

    localparam logic [2:0] C_N = 3'b001;
    localparam logic [2:0] C_D = 3'b010;
    localparam logic [2:0] C_Q = 3'b100;

    logic          clk = 1'b0;
    logic          clr;
    logic [2:0]    coin;
    logic [NI-1:0] choice;
    logic          cancel;
    logic [NI-1:0] item;
    logic [CW-1:0] total;
    logic [CW-1:0] cost_or_ret;
    logic [2:0]    change_coin;
    logic          coin_reject;
    logic          busy;

    vending_machine_param #(
        .NUM_ITEMS  (NI),
        .CREDIT_W   (CW),
        .PRICES     ({8'd30, 8'd25, 8'd20, 8'd15}),
        .MAX_CREDIT (MAXC),
        .TICK_DIV   (TD)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .coin        (coin),
        .choice      (choice),
        .cancel      (cancel),
        .item        (item),
        .total       (total),
        .cost_or_ret (cost_or_ret),
        .change_coin (change_coin),
        .coin_reject (coin_reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_item;
        int e_total;
        int e_cor;
        int e_change;
        int e_reject;
        int e_busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: credit in cents, a displayed amount, and the pending
    // change worked out up front as a list of coins.
    int   m_credit;
    int   m_shown;
    int   m_item;
    int   m_vending;
    int   m_change_q[$];
    int   price_tab[NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, expv);
        end
    endtask

    function automatic int coin_cents(input logic [2:0] c);
        case (c)
            C_N:     return 5;
            C_D:     return 10;
            C_Q:     return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int cents_coin(input int v);
        if (v == 25) return 4;
        if (v == 10) return 2;
        if (v == 5)  return 1;
        return 0;
    endfunction

    task automatic plan_change(input int amt);
        int rest;
        rest = amt;
        m_change_q.delete();
        for (int i = 0; i < amt / 25; i++) m_change_q.push_back(25);
        rest = rest % 25;
        for (int i = 0; i < rest / 10; i++) m_change_q.push_back(10);
        rest = rest % 10;
        for (int i = 0; i < rest / 5; i++) m_change_q.push_back(5);
    endtask

    task automatic do_vend(input int funds, input int price, input logic [NI-1:0] ch);
        m_shown   = funds - price;
        m_item    = int'(ch);
        m_credit  = 0;
        m_vending = 1;
        plan_change(m_shown);
    endtask

    task automatic model_reset();
        m_credit  = 0;
        m_shown   = 0;
        m_item    = 0;
        m_vending = 0;
        m_change_q.delete();
    endtask

    task automatic model_step(input logic [2:0] c, input logic [NI-1:0] ch, input logic cn);
        exp_t e;
        int   cv;
        int   price;
        int   v;
        int   rej;
        int   chg;
        bit   vc;
        bit   fits;
        rej   = 0;
        chg   = 0;
        price = 0;
        cv    = ($countones(c) == 1) ? coin_cents(c) : 0;
        vc    = ($countones(ch) == 1);
        for (int k = 0; k < NI; k++) if (ch[k]) price = price_tab[k];
        fits  = (cv > 0) && (m_credit + cv <= MAXC);
        if (m_vending != 0) begin
            m_vending = 0;
            m_item    = 0;
            rej       = (c != 0);
        end else if (m_change_q.size() > 0) begin
            v       = m_change_q.pop_front();
            chg     = cents_coin(v);
            m_shown = m_shown - v;
            rej     = (c != 0);
        end else if (cn && m_credit > 0) begin
            m_shown = m_credit;
            plan_change(m_credit);
            m_credit = 0;
            rej      = (c != 0);
        end else if (vc && m_credit >= price) begin
            do_vend(m_credit, price, ch);
            rej = (c != 0);
        end else if (vc && fits && (m_credit + cv >= price)) begin
            do_vend(m_credit + cv, price, ch);
        end else begin
            if (vc) m_shown = price;
            if (fits) m_credit = m_credit + cv;
            else rej = (c != 0);
        end
        e.e_item   = m_item;
        e.e_total  = m_credit;
        e.e_cor    = m_shown;
        e.e_change = chg;
        e.e_reject = rej;
        e.e_busy   = (m_vending != 0 || m_change_q.size() > 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Called just after a tick edge; holds inputs across the next tick edge.
    task automatic step(input logic [2:0] c, input logic [NI-1:0] ch, input logic cn);
        #2;
        coin   = c;
        choice = ch;
        cancel = cn;
        model_step(c, ch, cn);
        repeat (TD) @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, '0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_item"}, item, 0);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_cor"}, cost_or_ret, 0);
        chk({tag, "_change"}, change_coin, 0);
        chk({tag, "_reject"}, coin_reject, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: counts clk edges since clr release and checks after every tick.
    initial begin
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(posedge clk);
            if (clr) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == TD) begin
                    cnt = 0;
                    #1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL no_expectation t=%0t actual=tick expected=none", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("item", item, e.e_item);
                        chk("total", total, e.e_total);
                        chk("cost_or_ret", cost_or_ret, e.e_cor);
                        chk("change_coin", change_coin, e.e_change);
                        chk("coin_reject", coin_reject, e.e_reject);
                        chk("busy", busy, e.e_busy);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]    rc;
        logic [NI-1:0] rch;
        logic          rcn;
        int            r;
        price_tab = '{15, 20, 25, 30};
        model_reset();
        clr    = 1'b1;
        coin   = '0;
        choice = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        clr = 1'b0;

        // exact payment
        step(C_D, 4'b0000, 1'b0);
        step(C_N, 4'b0000, 1'b0);
        step(3'b000, 4'b0001, 1'b0);
        idle(2);
        // overpay, change quarter then nickel
        step(C_Q, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(3'b000, 4'b0010, 1'b0);
        idle(4);
        // credit ceiling, then refund
        step(C_Q, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(C_D, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(3'b000, 4'b0000, 1'b1);
        idle(5);
        // short credit shows price, then cancel
        step(C_D, 4'b0000, 1'b0);
        step(3'b000, 4'b1000, 1'b0);
        step(3'b000, 4'b0000, 1'b1);
        idle(3);
        // multi-hot coin, coin completing a vend, coin alongside an already-paid vend
        step(3'b011, 4'b0000, 1'b0);
        step(C_Q, 4'b0001, 1'b0);
        idle(3);
        step(C_D, 4'b0000, 1'b0);
        step(C_D, 4'b0000, 1'b0);
        step(C_Q, 4'b0001, 1'b0);
        idle(3);
        // invalid choices, cancel with coin, cancel in idle with coin
        step(C_D, 4'b0000, 1'b0);
        step(3'b000, 4'b0011, 1'b0);
        step(C_N, 4'b0000, 1'b1);
        idle(3);
        step(C_N, 4'b0000, 1'b1);
        step(3'b000, 4'b0000, 1'b1);
        idle(3);

        // clr during payout
        step(C_Q, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(C_Q, 4'b0000, 1'b0);
        step(3'b000, 4'b0001, 1'b0);
        idle(2);
        @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        check_zero("clr_async");
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("clr_hold_change", change_coin, 0);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        idle(4);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rc = 3'b000;
            else if (r < 9) rc = 3'(1 << $urandom_range(0, 2));
            else            rc = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r < 6)      rch = '0;
            else if (r < 9) rch = NI'(1 << $urandom_range(0, NI - 1));
            else            rch = NI'($urandom_range(0, 15));
            rcn = ($urandom_range(0, 11) == 0);
            step(rc, rch, rcn);
        end
        idle(8);

        for (int i = 0; i < 4 * TD && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
